// File: rtl/debounce_multi.sv
// Multi-channel push-button/switch debouncer: 2-flop sync, shared prescaled tick, per-channel integrator.
// Optional long-press detection is built only when DEBOUNCE_HOLD_EN is defined.
module debounce_multi #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned STABLE_COUNT = 8,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned HOLD_TICKS   = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change,
    output logic [CHANNELS-1:0] hold
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = $clog2(STABLE_COUNT + 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_COUNT - 1);

    if (CHANNELS == 0 || STABLE_COUNT == 0 || PRESCALE == 0 || HOLD_TICKS == 0) begin : g_bad_param
        $error("debounce_multi: all parameters must be >= 1");
    end

    logic [CHANNELS-1:0]          sync1;
    logic [CHANNELS-1:0]          sync2;
    logic [PW-1:0]                pcnt;
    logic                         tick;
    logic [CHANNELS-1:0][CW-1:0]  cnt;
    logic [CHANNELS-1:0][CW-1:0]  cnt_nxt;
    logic [CHANNELS-1:0]          level_nxt;
    logic [CHANNELS-1:0]          rise_nxt;
    logic [CHANNELS-1:0]          fall_nxt;

    // Metastability guard on the raw pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Shared sample-tick prescaler; with PRESCALE=1 PMAX is 0 and tick is always high
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (pcnt == PMAX) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign tick = (pcnt == PMAX);

    // Integrator: a level flips only after STABLE_COUNT consecutive disagreeing ticks
    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tick) begin
                if (sync2[i] == level[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CMAX) begin
                    cnt_nxt[i]   = '0;
                    level_nxt[i] = sync2[i];
                    rise_nxt[i]  = sync2[i];
                    fall_nxt[i]  = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            level      <= '0;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            level      <= level_nxt;
            rise       <= rise_nxt;
            fall       <= fall_nxt;
            any_change <= |(rise_nxt | fall_nxt);
        end
    end

`ifdef DEBOUNCE_HOLD_EN
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_TICKS);

    logic [CHANNELS-1:0][HW-1:0] hcnt;
    logic [CHANNELS-1:0][HW-1:0] hcnt_nxt;
    logic [CHANNELS-1:0]         hold_nxt;

    // Saturating ticks-at-high counter; keyed on the next level so hold drops with level
    always_comb begin
        hcnt_nxt = hcnt;
        hold_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!level_nxt[i]) begin
                hcnt_nxt[i] = '0;
            end else if (tick && level[i] && (hcnt[i] != HMAX)) begin
                hcnt_nxt[i] = hcnt[i] + HW'(1);
            end
            hold_nxt[i] = level_nxt[i] && (hcnt_nxt[i] == HMAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            hold <= '0;
        end else begin
            hcnt <= hcnt_nxt;
            hold <= hold_nxt;
        end
    end
`else
    assign hold = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: two instances (fast / prescaled) against a tick-level reference model.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;

    logic [3:0] level0, rise0, fall0, hold0;
    logic       anyc0;
    logic [3:0] level1, rise1, fall1, hold1;
    logic       anyc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(4), .STABLE_COUNT(8), .PRESCALE(1), .HOLD_TICKS(16)) dut0 (
        .clk(clk), .reset(reset), .btn_in(btn),
        .level(level0), .rise(rise0), .fall(fall0), .any_change(anyc0), .hold(hold0)
    );

    debounce_multi #(.CHANNELS(4), .STABLE_COUNT(2), .PRESCALE(4), .HOLD_TICKS(16)) dut1 (
        .clk(clk), .reset(reset), .btn_in(btn),
        .level(level1), .rise(rise1), .fall(fall1), .any_change(anyc1), .hold(hold1)
    );

    // Reference model state: per-instance levels, run lengths of disagreeing ticks, ticks spent high
    localparam int HT = 16;
    bit [3:0] h1, h2;
    int       n;
    bit [3:0] mlvl [2];
    bit [3:0] mrise [2];
    bit [3:0] mfall [2];
    bit [3:0] mhold [2];
    bit       many [2];
    int       run [2][4];
    int       hticks [2][4];

    function automatic int sc(input int d);
        return (d == 0) ? 8 : 2;
    endfunction

    function automatic int pr(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit [3:0] b, input bit r);
        bit [3:0] seen;
        bit       tk;
        bit       oldl;
        if (r) begin
            h1 = '0; h2 = '0; n = 0;
            for (int d = 0; d < 2; d++) begin
                mlvl[d] = '0; mrise[d] = '0; mfall[d] = '0; mhold[d] = '0; many[d] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    run[d][c] = 0; hticks[d][c] = 0;
                end
            end
        end else begin
            seen = h2;
            h2 = h1;
            h1 = b;
            for (int d = 0; d < 2; d++) begin
                tk = ((n % pr(d)) == pr(d) - 1);
                mrise[d] = '0;
                mfall[d] = '0;
                for (int c = 0; c < 4; c++) begin
                    oldl = mlvl[d][c];
                    if (tk) begin
                        if (seen[c] != oldl) begin
                            run[d][c]++;
                            if (run[d][c] == sc(d)) begin
                                run[d][c] = 0;
                                mlvl[d][c] = seen[c];
                                if (seen[c]) mrise[d][c] = 1'b1;
                                else         mfall[d][c] = 1'b1;
                            end
                        end else begin
                            run[d][c] = 0;
                        end
                    end
                    if (!mlvl[d][c]) hticks[d][c] = 0;
                    else if (tk && oldl && hticks[d][c] < HT) hticks[d][c]++;
`ifdef DEBOUNCE_HOLD_EN
                    mhold[d][c] = mlvl[d][c] && (hticks[d][c] == HT);
`else
                    mhold[d][c] = 1'b0;
`endif
                end
                many[d] = |(mrise[d] | mfall[d]);
            end
            n++;
        end
    endtask

    task automatic compare_all();
        logic [3:0] ol, orr, of, oh;
        logic       oa;
        for (int d = 0; d < 2; d++) begin
            ol  = (d == 0) ? level0 : level1;
            orr = (d == 0) ? rise0  : rise1;
            of  = (d == 0) ? fall0  : fall1;
            oh  = (d == 0) ? hold0  : hold1;
            oa  = (d == 0) ? anyc0  : anyc1;
            chk($sformatf("d%0d_level@%0t", d, $time), 32'(ol),  32'(mlvl[d]));
            chk($sformatf("d%0d_rise@%0t", d, $time),  32'(orr), 32'(mrise[d]));
            chk($sformatf("d%0d_fall@%0t", d, $time),  32'(of),  32'(mfall[d]));
            chk($sformatf("d%0d_hold@%0t", d, $time),  32'(oh),  32'(mhold[d]));
            chk($sformatf("d%0d_any@%0t", d, $time),   32'(oa),  32'(many[d]));
        end
    endtask

    // One clock: capture pre-edge stimulus, step the model, sample DUTs 1ns after the edge
    task automatic cyc();
        bit [3:0] b;
        bit       r;
        b = btn;
        r = reset;
        @(posedge clk);
        #1;
        model_step(b, r);
        compare_all();
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    // Edges (1-based) until each instance's level[ch] equals want; -1 if never within maxc
    task automatic measure(input int maxc, input bit want, input int ch,
                           output int lat0, output int lat1, output bit st0);
        lat0 = -1; lat1 = -1; st0 = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            cyc();
            if (lat0 < 0 && level0[ch] == want) begin
                lat0 = c;
                st0 = want ? rise0[ch] : fall0[ch];
            end
            if (lat1 < 0 && level1[ch] == want) lat1 = c;
            if (lat0 >= 0 && lat1 >= 0) break;
        end
    endtask

    initial begin
        int  l0, l1, hl;
        bit  s0;
        bit  sticky;

        reset = 1'b1;
        btn   = '0;
        cycles(3);
        chk("reset_level0", 32'(level0), 32'h0);
        chk("reset_any0", 32'(anyc0), 32'h0);
        reset = 1'b0;
        cycles(4);

        // Clean press and release on channel 0
        btn[0] = 1'b1;
        measure(20, 1'b1, 0, l0, l1, s0);
        chk("press_latency0", 32'(l0), 32'd10);
        chk("press_rise0", 32'(s0), 32'd1);
        chk("press_any0", 32'(anyc0), 32'd1);
        chk("press_latency1_in_6_9", 32'((l1 - 1 >= 6) && (l1 - 1 <= 9)), 32'd1);
        cyc();
        chk("rise_one_cycle", 32'(rise0[0]), 32'd0);
        cycles(12);
        btn[0] = 1'b0;
        measure(20, 1'b0, 0, l0, l1, s0);
        chk("release_latency0", 32'(l0), 32'd10);
        chk("release_fall0", 32'(s0), 32'd1);
        cycles(12);

        // Bounce on channel 1: 3-cycle segments never survive 8 ticks
        sticky = 1'b0;
        for (int t = 0; t < 20; t++) begin
            btn[1] = ~btn[1];
            for (int k = 0; k < 3; k++) begin
                cyc();
                sticky |= rise0[1] | fall0[1];
            end
        end
        chk("bounce_no_strobe0", 32'(sticky), 32'd0);
        btn[1] = 1'b1;
        measure(20, 1'b1, 1, l0, l1, s0);
        chk("bounce_settle_latency0", 32'(l0), 32'd10);
        chk("bounce_settle_rise0", 32'(s0), 32'd1);

        // Simultaneous rise on 1011
        btn = '0;
        cycles(25);
        btn = 4'b1011;
        hl = -1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (rise0 != 4'b0000) begin
                hl = c;
                break;
            end
        end
        chk("simul_latency0", 32'(hl), 32'd10);
        chk("simul_rise0", 32'(rise0), 32'hb);
        chk("simul_any0", 32'(anyc0), 32'd1);
        cyc();
        chk("simul_any0_drop", 32'(anyc0), 32'd0);

        // Prescaled instance: 5-cycle pulse aligned to cover exactly one tick
        btn = '0;
        cycles(25);
        while ((n % 4) != 2) cyc();
        btn[0] = 1'b1;
        cycles(5);
        btn[0] = 1'b0;
        sticky = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            sticky |= level1[0] | rise1[0];
        end
        chk("prescale_pulse_rejected", 32'(sticky), 32'd0);

        // Reset while channel 2 integrator sits at 5
        btn[2] = 1'b1;
        cycles(7);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("in_reset_outputs0", 32'({level0, rise0, fall0, hold0, anyc0}), 32'h0);
        end
        reset = 1'b0;
        measure(20, 1'b1, 2, l0, l1, s0);
        chk("post_reset_latency0", 32'(l0), 32'd10);
        chk("post_reset_rise0", 32'(s0), 32'd1);

        // Long press on channel 2
        hl = -1;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (hl < 0 && hold0[2]) hl = c;
        end
`ifdef DEBOUNCE_HOLD_EN
        chk("hold_latency0", 32'(hl), 32'd16);
`else
        chk("hold_never0", 32'(hl), 32'hffffffff);
`endif
        btn[2] = 1'b0;
        measure(20, 1'b0, 2, l0, l1, s0);
        chk("hold_release_hold0", 32'(hold0[2]), 32'd0);

        // Randomised traffic: fast then slow input changes with occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) btn = 4'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            cyc();
        end
        reset = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 79) == 0) btn = 4'($urandom);
            reset = ($urandom_range(0, 999) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
